// File: rtl/stream_reader_if.sv
// stream_reader_if: bundles the three channels that stream_reader serves.
//   Request  : req_valid / req_ready / req_len / req_addr_address, plus inProgress status
//   Data out : data_valid / data_ready / data (FIFO head toward the core)
//   Memory   : mem_ar_valid / mem_ar_ready / mem_ar_addr and mem_r_valid / mem_r_data
// Optional macro STREAM_READER_ERR_EN adds mem_r_err (memory -> reader) and err (reader -> core).
// Modport slave is the reader itself; master is the environment (core + memory).
interface stream_reader_if #(
    parameter int unsigned DATA_BYTES = 16,
    parameter int unsigned ADDR_BITS  = 64,
    parameter int unsigned LEN_BITS   = 34
);
    logic                    req_valid;
    logic                    req_ready;
    logic [LEN_BITS-1:0]     req_len;
    logic [ADDR_BITS-1:0]    req_addr_address;
    logic                    inProgress;
    logic                    data_valid;
    logic                    data_ready;
    logic [DATA_BYTES*8-1:0] data;
    logic                    mem_ar_valid;
    logic                    mem_ar_ready;
    logic [ADDR_BITS-1:0]    mem_ar_addr;
    logic                    mem_r_valid;
    logic [DATA_BYTES*8-1:0] mem_r_data;
`ifdef STREAM_READER_ERR_EN
    logic                    mem_r_err;
    logic                    err;
`endif

    modport slave (
        input  req_valid, req_len, req_addr_address, data_ready, mem_ar_ready,
               mem_r_valid, mem_r_data,
        output req_ready, inProgress, data_valid, data, mem_ar_valid, mem_ar_addr
`ifdef STREAM_READER_ERR_EN
        , input mem_r_err
        , output err
`endif
    );

    modport master (
        output req_valid, req_len, req_addr_address, data_ready, mem_ar_ready,
               mem_r_valid, mem_r_data,
        input  req_ready, inProgress, data_valid, data, mem_ar_valid, mem_ar_addr
`ifdef STREAM_READER_ERR_EN
        , output mem_r_err
        , input  err
`endif
    );
endinterface

// File: rtl/stream_reader.sv
// stream_reader: read-channel responder for the accelerator cores. Takes one byte-length/address
// request at a time, splits it into single-beat memory reads, buffers returned beats in a
// credit-managed FIFO and streams them to the core in order.
// Ports:
//   clock   - single clock, rising edge
//   aresetn - asynchronous active-low reset
//   bus     - stream_reader_if.slave (request, data-out and memory channels)
// Optional feature macro STREAM_READER_ERR_EN: sticky err flag set by mem_r_valid && mem_r_err,
// cleared on the next request accept.
module stream_reader #(
    parameter int unsigned DATA_BYTES = 16,
    parameter int unsigned ADDR_BITS  = 64,
    parameter int unsigned LEN_BITS   = 34,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input logic          clock,
    input logic          aresetn,
    stream_reader_if.slave bus
);
    localparam int unsigned OFF_BITS  = $clog2(DATA_BYTES);
    localparam int unsigned PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS  = PTR_BITS + 1;
    localparam int unsigned DATA_BITS = DATA_BYTES * 8;

    localparam logic [ADDR_BITS-1:0] ADDR_MASK = ~(ADDR_BITS'(DATA_BYTES - 1));
    localparam logic [ADDR_BITS-1:0] ADDR_STEP = ADDR_BITS'(DATA_BYTES);
    localparam logic [CNT_BITS:0]    DEPTH_SUM = (CNT_BITS + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e               r_state;
    logic                 r_req_ready;
    logic                 r_in_progress;
    logic [ADDR_BITS-1:0] r_addr;
    logic [LEN_BITS-1:0]  r_beats;
    logic [LEN_BITS-1:0]  r_issued;
    logic [LEN_BITS-1:0]  r_consumed;
    logic [CNT_BITS-1:0]  r_inflight;
    logic [CNT_BITS-1:0]  r_fifo_count;
    logic [PTR_BITS-1:0]  r_wr_ptr;
    logic [PTR_BITS-1:0]  r_rd_ptr;
    logic [DATA_BITS-1:0] r_fifo [FIFO_DEPTH];

    logic                 w_accept;
    logic [LEN_BITS-1:0]  w_req_beats;
    logic                 w_credit;
    logic                 w_ar_valid;
    logic                 w_ar_fire;
    logic                 w_push;
    logic                 w_pop;

    assign w_accept    = r_req_ready && bus.req_valid;
    assign w_req_beats = bus.req_len >> OFF_BITS;
    // Reads in flight plus beats already buffered may never exceed the FIFO, so every
    // returned beat is guaranteed a slot.
    assign w_credit    = ({1'b0, r_inflight} + {1'b0, r_fifo_count}) < DEPTH_SUM;
    assign w_ar_valid  = (r_state == StIssue) && (r_issued < r_beats) && w_credit;
    assign w_ar_fire   = w_ar_valid && bus.mem_ar_ready;
    assign w_push      = bus.mem_r_valid;
    assign w_pop       = (r_fifo_count != '0) && bus.data_ready;

    assign bus.req_ready    = r_req_ready;
    assign bus.inProgress   = r_in_progress;
    assign bus.mem_ar_valid = w_ar_valid;
    assign bus.mem_ar_addr  = r_addr;
    assign bus.data_valid   = (r_fifo_count != '0);
    // Forced to zero when empty so the unreset storage never leaks onto data.
    assign bus.data         = (r_fifo_count != '0) ? r_fifo[r_rd_ptr] : '0;

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= StIdle;
            r_req_ready   <= 1'b0;
            r_in_progress <= 1'b0;
            r_addr        <= '0;
            r_beats       <= '0;
            r_issued      <= '0;
            r_consumed    <= '0;
            r_inflight    <= '0;
            r_fifo_count  <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_inflight   <= r_inflight + CNT_BITS'(w_ar_fire) - CNT_BITS'(w_push);
            r_fifo_count <= r_fifo_count + CNT_BITS'(w_push) - CNT_BITS'(w_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_BITS'(1);
                r_consumed <= r_consumed + LEN_BITS'(1);
            end

            case (r_state)
                StIdle: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_beats    <= w_req_beats;
                        r_addr     <= bus.req_addr_address & ADDR_MASK;
                        r_issued   <= '0;
                        r_consumed <= '0;
                        // A sub-beat length carries no data: stay idle and ready.
                        if (w_req_beats != '0) begin
                            r_state       <= StIssue;
                            r_req_ready   <= 1'b0;
                            r_in_progress <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (w_ar_fire) begin
                        r_addr   <= r_addr + ADDR_STEP;
                        r_issued <= r_issued + LEN_BITS'(1);
                    end
                    if (r_issued == r_beats) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (r_consumed == r_beats) begin
                        r_state       <= StIdle;
                        r_req_ready   <= 1'b1;
                        r_in_progress <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.mem_r_data;
        end
    end

`ifdef STREAM_READER_ERR_EN
    logic r_err;

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (bus.mem_r_valid && bus.mem_r_err) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`endif
endmodule

// File: tb/tb_stream_reader.sv
// tb_stream_reader: randomized bench for stream_reader against a queue-based reference model.
// The model expands each request into its list of beat addresses and payloads with plain
// arithmetic; a memory model answers reads in order with random latency.
module tb_stream_reader;
    localparam int unsigned DB = 16;
    localparam int unsigned AB = 64;
    localparam int unsigned LB = 34;
    localparam int unsigned FD = 8;
    localparam int unsigned DW = DB * 8;

    logic clock = 1'b0;
    logic aresetn = 1'b1;

    always #5 clock = ~clock;

    stream_reader_if #(.DATA_BYTES(DB), .ADDR_BITS(AB), .LEN_BITS(LB)) bus ();

    stream_reader #(
        .DATA_BYTES(DB),
        .ADDR_BITS (AB),
        .LEN_BITS  (LB),
        .FIFO_DEPTH(FD)
    ) u_dut (
        .clock  (clock),
        .aresetn(aresetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [AB-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [DW-1:0] mem_q[$];
    int n_ar, n_pop, max_out, exp_beats, ret_idx, err_beat;
    bit tog, err_exp;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AB-1:0] a);
        return {a ^ 64'hC3A5_0F1E_9B7D_2468, a + 64'h1111};
    endfunction

    task automatic idle_inputs();
        bus.req_valid        = 1'b0;
        bus.req_len          = '0;
        bus.req_addr_address = '0;
        bus.data_ready       = 1'b1;
        bus.mem_ar_ready     = 1'b0;
        bus.mem_r_valid      = 1'b0;
        bus.mem_r_data       = '0;
`ifdef STREAM_READER_ERR_EN
        bus.mem_r_err        = 1'b0;
`endif
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_req_ready"}, bus.req_ready, 0);
        check({pfx, "_inprog"}, bus.inProgress, 0);
        check({pfx, "_data_valid"}, bus.data_valid, 0);
        check({pfx, "_ar_valid"}, bus.mem_ar_valid, 0);
        check({pfx, "_ar_addr"}, bus.mem_ar_addr, 0);
        check({pfx, "_data"}, bus.data, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #2 aresetn = 1'b0;
        #1 check_outputs_zero("rst");
        idle_inputs();
        exp_addr_q.delete();
        exp_data_q.delete();
        mem_q.delete();
        err_exp = 1'b0;
        repeat (2) @(negedge clock);
        #2 aresetn = 1'b1;
        #1 check("rst_rel_ready_low", bus.req_ready, 0);
        @(negedge clock);
        check("rst_rel_ready_high", bus.req_ready, 1);
        check("rst_rel_inprog", bus.inProgress, 0);
    endtask

    // One clock of core + memory behaviour, evaluated between edges.
    task automatic cycle(input int ar_p, input int d_p, input int r_p);
        bit ar_rdy, d_rdy;
        @(negedge clock);
`ifdef STREAM_READER_ERR_EN
        check("err", bus.err, err_exp);
`endif
        if (ar_p < 0) begin
            tog    = ~tog;
            ar_rdy = tog;
        end else begin
            ar_rdy = int'($urandom_range(99)) < ar_p;
        end
        d_rdy = int'($urandom_range(99)) < d_p;
        bus.mem_ar_ready = ar_rdy;
        bus.data_ready   = d_rdy;
        // Junk requests while busy must be ignored.
        bus.req_valid        = ($urandom_range(3) == 0);
        bus.req_len          = LB'({$urandom, $urandom});
        bus.req_addr_address = {$urandom, $urandom};
        if (mem_q.size() > 0 && int'($urandom_range(99)) < r_p) begin
            bus.mem_r_valid = 1'b1;
            bus.mem_r_data  = mem_q.pop_front();
            ret_idx++;
`ifdef STREAM_READER_ERR_EN
            bus.mem_r_err = (ret_idx == err_beat);
            if (ret_idx == err_beat) err_exp = 1'b1;
`endif
        end else begin
            bus.mem_r_valid = 1'b0;
            bus.mem_r_data  = {4{$urandom}};
`ifdef STREAM_READER_ERR_EN
            bus.mem_r_err   = 1'($urandom_range(1));
`endif
        end
        if (bus.mem_ar_valid && ar_rdy) begin
            if (exp_addr_q.size() == 0) check("ar_extra", 1, 0);
            else check("ar_addr", bus.mem_ar_addr, exp_addr_q.pop_front());
            mem_q.push_back(mem_word(bus.mem_ar_addr));
            n_ar++;
        end
        if (bus.data_valid && d_rdy) begin
            if (exp_data_q.size() == 0) check("data_extra", 1, 0);
            else check("data", bus.data, exp_data_q.pop_front());
            n_pop++;
        end
        if (n_ar - n_pop > max_out) max_out = n_ar - n_pop;
    endtask

    task automatic start_req(input logic [LB-1:0] len, input logic [AB-1:0] addr);
        logic [AB-1:0] a;
        @(negedge clock);
        bus.req_valid        = 1'b1;
        bus.req_len          = len;
        bus.req_addr_address = addr;
        bus.mem_r_valid      = 1'b0;
        check("req_ready_idle", bus.req_ready, 1);
        exp_beats = int'(len / LB'(DB));
        a = addr - (addr % AB'(DB));
        exp_addr_q.delete();
        exp_data_q.delete();
        mem_q.delete();
        for (int i = 0; i < exp_beats; i++) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_word(a));
            a = a + AB'(DB);
        end
        n_ar    = 0;
        n_pop   = 0;
        max_out = 0;
        ret_idx = 0;
        err_exp = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("inprog_start", bus.inProgress, exp_beats != 0);
        check("req_ready_after", bus.req_ready, exp_beats == 0);
`ifdef STREAM_READER_ERR_EN
        check("err_cleared", bus.err, 0);
`endif
        if (exp_beats == 0) begin
            repeat (3) begin
                check("zero_ar_valid", bus.mem_ar_valid, 0);
                check("zero_inprog", bus.inProgress, 0);
                check("zero_req_ready", bus.req_ready, 1);
                @(negedge clock);
            end
        end
    endtask

    task automatic run_until(input int target, input int ar_p, input int d_p, input int r_p);
        int budget = 4000;
        while (n_pop < target && budget > 0) begin
            cycle(ar_p, d_p, r_p);
            budget--;
        end
        check("pops_reached", n_pop >= target, 1);
    endtask

    task automatic finish_req();
        idle_inputs();
        @(negedge clock);
        check("inprog_tail", bus.inProgress, 1);
        @(negedge clock);
        check("inprog_done", bus.inProgress, 0);
        check("req_ready_done", bus.req_ready, 1);
        check("beats_issued", n_ar, exp_beats);
        check("beats_popped", n_pop, exp_beats);
        check("credit", max_out <= int'(FD), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tog      = 1'b0;
        err_exp  = 1'b0;
        err_beat = 0;
        idle_inputs();
        pulse_reset();

        // Basic order, always-ready memory and core.
        start_req(34'd64, 64'h1000);
        run_until(4, 100, 100, 100);
        finish_req();

        // Zero and sub-beat lengths.
        start_req(34'd0, 64'h2000);
        start_req(34'd15, 64'h2000);

        // Misaligned start address.
        start_req(34'd32, 64'h100F);
        run_until(2, 100, 100, 100);
        finish_req();

        // Address wrap at the top of the address space.
        start_req(34'd64, 64'hFFFF_FFFF_FFFF_FFE5);
        run_until(4, 100, 100, 100);
        finish_req();

        // Back-pressure: credits cap reads at the FIFO depth.
        start_req(34'd256, 64'h2000);
        repeat (40) cycle(100, 0, 100);
        check("bp_ar_count", n_ar, FD);
        check("bp_ar_stalled", bus.mem_ar_valid, 0);
        check("bp_data_valid", bus.data_valid, 1);
        run_until(16, 100, 100, 100);
        finish_req();

        // Simultaneous push/pop with toggling address ready.
        start_req(34'd320, 64'h5000);
        run_until(20, -1, 100, 100);
        finish_req();

        // Randomized traffic.
        for (int t = 0; t < 6; t++) begin
            logic [LB-1:0] len;
            len = LB'($urandom_range(400));
            start_req(len, {$urandom, $urandom});
            if (exp_beats != 0) begin
                run_until(exp_beats, 30 + int'($urandom_range(70)),
                          30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)));
                finish_req();
            end
        end

        // Reset in the middle of a transfer.
        start_req(34'd128, 64'h6000);
        run_until(3, 100, 100, 100);
        pulse_reset();
        start_req(34'd48, 64'h7000);
        run_until(3, 70, 70, 70);
        finish_req();

`ifdef STREAM_READER_ERR_EN
        err_beat = 2;
        start_req(34'd64, 64'h3000);
        run_until(4, 100, 100, 100);
        check("err_sticky", bus.err, 1);
        finish_req();
        check("err_held_idle", bus.err, 1);
        err_beat = 0;
        start_req(34'd32, 64'h3100);
        run_until(2, 100, 100, 100);
        finish_req();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/stream_reader.md
Name: stream_reader

Overview:
- Read-channel responder for the accelerator cores: it serves the `*_req` / `*_data` / `*_inProgress` read interface that a core (e.g. the systolic array core) drives for weights and activations.
- Accepts one byte-length/address request at a time and splits it into single-beat memory reads.
- Buffers returned beats in a credit-managed FIFO and streams them to the core in order.

Parameters:
- DATA_BYTES, 16, bytes per beat; data width is DATA_BYTES*8; must be a power of two.
- ADDR_BITS, 64, address width.
- LEN_BITS, 34, request length field width, in bytes.
- FIFO_DEPTH, 8, beat buffer depth; power of two, at least 2; also the cap on reads in flight.

Ports:
- clock  in  1  single clock, rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE.
- req_len  in  LEN_BITS  transfer length in bytes.
- req_addr_address  in  ADDR_BITS  start byte address.
- inProgress  out  1  transfer active.
- data_valid  out  1  beat available to core.
- data_ready  in  1  core accepts beat.
- data  out  DATA_BYTES*8  beat payload.
- mem_ar_valid  out  1  memory read address valid.
- mem_ar_ready  in  1  memory accepts address.
- mem_ar_addr  out  ADDR_BITS  beat address, DATA_BYTES-aligned.
- mem_r_valid  in  1  read data returned; always accepted, no ready signal.
- mem_r_data  in  DATA_BYTES*8  read data.

Behaviour:
- Reset (aresetn low, asynchronous): state=IDLE, all counters and FIFO pointers zero.
  - Outputs during reset: req_ready=0, inProgress=0, data_valid=0, mem_ar_valid=0, mem_ar_addr=0, data=0.
  - req_ready rises the first cycle after aresetn is deasserted.
- Reset mid-transfer aborts the transfer; the memory side must be reset in the same domain so no stale responses arrive.
- Request latch (IDLE, req_valid&&req_ready):
  - beats = req_len >> log2(DATA_BYTES); low length bits are truncated.
  - addr = req_addr_address with the low log2(DATA_BYTES) bits cleared.
  - If beats==0, stay in IDLE: no memory traffic, inProgress stays 0.
  - Otherwise go to ISSUE and assert inProgress from the next cycle.
- ISSUE state:
  - mem_ar_valid = (issued < beats) && (inflight + fifo_count < FIFO_DEPTH).
  - Each mem_ar handshake advances addr by DATA_BYTES and increments issued and inflight.
  - mem_ar_addr and mem_ar_valid stay stable while valid and not ready.
  - When issued==beats, go to DRAIN.
- DRAIN state: no new addresses; wait until consumed==beats, then go to IDLE.
  - inProgress drops and req_ready rises in the same edge.
- Read return: each mem_r_valid pushes one beat into the FIFO and decrements inflight.
  - The credit rule guarantees the push can never overflow.
- Output side:
  - data_valid = FIFO not empty; data = FIFO head.
  - A pop on data_valid&&data_ready increments consumed.
  - Latency: a beat returned at edge N is visible on data at edge N+1; there is no bypass.
  - Push and pop in the same cycle are both honoured; fifo_count is unchanged.
- Address wrap: addr arithmetic is modulo 2^ADDR_BITS and wraps silently.
- Counter widths:
  - issued, consumed and beats are LEN_BITS wide.
  - inflight and fifo_count are log2(FIFO_DEPTH)+1 bits wide.
- Ordering: memory returns data in request order; no reordering is performed.
- New requests are ignored (req_ready=0) outside IDLE.

Optional Feature:
- Macro STREAM_READER_ERR_EN.
- Defined:
  - Extra input mem_r_err (1 bit), sampled with mem_r_valid.
  - Extra output err (1 bit), sticky: set on any mem_r_valid&&mem_r_err.
  - err clears on the next request accept; reset value 0.
  - The erroneous beat is still delivered to the core and the transfer completes normally.
- Undefined: neither port exists and read errors are invisible.

Test Plan:
- Basic order, always-ready memory and core: len=64, addr=0x1000, DATA_BYTES=16 -> mem_ar_addr 0x1000, 0x1010, 0x1020, 0x1030; 4 data beats in order; inProgress high from the cycle after accept until the edge after the 4th pop.
- Zero and short length:
  - len=0 -> no mem_ar_valid, inProgress stays 0, req_ready stays 1.
  - len=15 -> same behaviour (0 beats).
- Misalignment: addr=0x100F, len=32 -> mem_ar_addr 0x1000, 0x1010.
- Back-pressure, FIFO_DEPTH=8, len=256 (16 beats), data_ready=0 -> exactly 8 mem_ar handshakes then mem_ar_valid=0; releasing data_ready delivers all 16 beats in order with no loss.
- Simultaneous traffic and mid-transfer reset:
  - Simultaneous push/pop every cycle with mem_ar_ready toggling 1,0,1,0 -> fifo_count never exceeds FIFO_DEPTH.
  - aresetn pulsed low after the 3rd beat -> all outputs 0 immediately; req_ready=1 the cycle after release.
- Error reporting (with STREAM_READER_ERR_EN), 4 beats with mem_r_err on beat 2 -> err=1 from the cycle after beat 2 returns; all 4 beats still delivered; err=0 after the next request is accepted.
